// File: rtl/guess_pkg.sv
// Shared types and helpers for the automatic guess-game opponent.
package guess_pkg;

   localparam int NLIGHTS = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      PRESS   = 2'd2,
      RELEASE = 2'd3
   } player_state_t;

   // Neighbouring button, used to lose on purpose.
   function automatic logic [NLIGHTS-1:0] rotl1(input logic [NLIGHTS-1:0] v);
      return {v[NLIGHTS-2:0], v[NLIGHTS-1]};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Synchronous-reset incrementer that sticks at its all-ones value.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + W'(1);
   end

endmodule

// File: rtl/guess_player.sv
// Automatic opponent: watches the game lights, presses a button after a
// reaction delay, and keeps score of the game's win/lose results.
module guess_player
   import guess_pkg::*;
#(
   parameter int unsigned DELAY   = 3,
   parameter int unsigned HOLD    = 2,
   parameter int unsigned SCORE_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               miss,
   input  logic [3:0]         y,
   input  logic               win,
   input  logic               lose,
   output logic [3:0]         b,
   output logic [SCORE_W-1:0] wins,
   output logic [SCORE_W-1:0] losses,
   output logic               busy,
   output logic               err
);

   localparam int unsigned CW = 8;

   player_state_t state, state_n;
   logic [3:0]    tgt, tgt_n, last, last_n, b_n;
   logic [CW-1:0] dcnt, dcnt_n, hcnt, hcnt_n;
   logic          busy_n;
   logic          win_q, lose_q;
   logic          y_ok, both, win_rise, lose_rise, result_rise;

   assign y_ok        = $onehot(y);
   assign both        = win & lose;
   assign win_rise    = win & ~win_q;
   assign lose_rise   = lose & ~lose_q;
   assign result_rise = win_rise | lose_rise;

   // State, counters, button drive and result edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         tgt    <= '0;
         last   <= '0;
         dcnt   <= '0;
         hcnt   <= '0;
         b      <= '0;
         busy   <= 1'b0;
         err    <= 1'b0;
         win_q  <= 1'b0;
         lose_q <= 1'b0;
      end else begin
         state  <= state_n;
         tgt    <= tgt_n;
         last   <= last_n;
         dcnt   <= dcnt_n;
         hcnt   <= hcnt_n;
         b      <= b_n;
         busy   <= busy_n;
         err    <= err | both;
         win_q  <= win;
         lose_q <= lose;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n = state;
      tgt_n   = tgt;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      b_n     = b;
      last_n  = (y == 4'd0) ? 4'd0 : last;
      case (state)
         IDLE: begin
            b_n = '0;
            if (en && y_ok && (y != last)) begin
               tgt_n   = y;
               dcnt_n  = '0;
               state_n = ARMED;
            end
         end
         ARMED: begin
            b_n = '0;
            if (!y_ok || !en || result_rise) begin
               state_n = IDLE;
            end else if (y != tgt) begin
               tgt_n  = y;
               dcnt_n = '0;
            end else if (dcnt == CW'(DELAY - 1)) begin
               state_n = PRESS;
               b_n     = miss ? rotl1(tgt) : tgt;
               hcnt_n  = '0;
               last_n  = tgt;
            end else begin
               dcnt_n = dcnt + CW'(1);
            end
         end
         PRESS: begin
            if (win || lose || (hcnt == CW'(HOLD - 1))) begin
               state_n = RELEASE;
               b_n     = '0;
            end else begin
               hcnt_n = hcnt + CW'(1);
            end
         end
         RELEASE: begin
            b_n = '0;
            // Wait for the light to move so the same target is not re-pressed.
            if (!win && !lose && (y != tgt))
               state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            b_n     = '0;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   sat_counter #(.W(SCORE_W)) u_wins (
      .clk   (clk),
      .reset (reset),
      .inc   (win_rise & ~both),
      .q     (wins)
   );

   sat_counter #(.W(SCORE_W)) u_losses (
      .clk   (clk),
      .reset (reset),
      .inc   (lose_rise & ~both),
      .q     (losses)
   );

endmodule

// File: tb/tb_guess_player.sv
// Bench for guess_player: directed table, hand sequences, and random
// stimulus against a behavioural model.
module tb_guess_player;

   logic       clk = 1'b0;
   logic       reset, en, miss, win, lose;
   logic [3:0] y;
   logic [3:0] b, b2;
   logic [7:0] wins, losses;
   logic [1:0] wins2, losses2;
   logic       busy, err, busy2, err2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   guess_player #(.DELAY(3), .HOLD(2), .SCORE_W(8)) dut (
      .clk(clk), .reset(reset), .en(en), .miss(miss), .y(y), .win(win), .lose(lose),
      .b(b), .wins(wins), .losses(losses), .busy(busy), .err(err)
   );

   guess_player #(.DELAY(3), .HOLD(2), .SCORE_W(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .miss(miss), .y(y), .win(win), .lose(lose),
      .b(b2), .wins(wins2), .losses(losses2), .busy(busy2), .err(err2)
   );

   typedef struct {
      logic       rst, en, miss;
      logic [3:0] y;
      logic       win, lose;
      logic [3:0] eb;
      logic       ebusy;
      logic [7:0] ew, el;
      logic       eerr;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [3:0] yy,
                               input logic w, input logic l, input logic [3:0] eb, input logic eby,
                               input logic [7:0] ew, input logic [7:0] el, input logic ee);
      vec_t v;
      v.rst = r; v.en = e; v.miss = m; v.y = yy; v.win = w; v.lose = l;
      v.eb = eb; v.ebusy = eby; v.ew = ew; v.el = el; v.eerr = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic m, input logic [3:0] yy,
                        input logic w, input logic l);
      reset = r; en = e; miss = m; y = yy; win = w; lose = l;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
   endtask

   // Behavioural model: phases with remaining-cycle countdowns.
   int         m_phase;            // 0 waiting, 1 reacting, 2 holding, 3 letting go
   int         m_left, m_hold;
   int         m_wins, m_losses;
   bit         m_err, m_pw, m_pl;
   logic [3:0] m_tgt, m_last, m_b;

   function automatic int cap(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_edge(input logic r, input logic e, input logic m, input logic [3:0] yy,
                             input logic w, input logic l);
      bit valid, wr, lr;
      if (r) begin
         m_phase = 0; m_left = 0; m_hold = 0; m_wins = 0; m_losses = 0;
         m_err = 0; m_pw = 0; m_pl = 0; m_tgt = 0; m_last = 0; m_b = 0;
         return;
      end
      valid = ($countones(yy) == 1);
      wr = w && !m_pw;
      lr = l && !m_pl;
      if (w && l) m_err = 1;
      else begin
         if (wr) m_wins++;
         if (lr) m_losses++;
      end
      m_pw = w; m_pl = l;
      case (m_phase)
         0: if (e && valid && yy != m_last) begin m_tgt = yy; m_left = 3; m_phase = 1; end
         1: begin
            if (!valid || !e || wr || lr) m_phase = 0;
            else if (yy != m_tgt) begin m_tgt = yy; m_left = 3; end
            else begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 2;
                  m_b = m ? (((m_tgt << 1) | (m_tgt >> 3)) & 4'hF) : m_tgt;
                  m_hold = 2;
                  m_last = m_tgt;
               end
            end
         end
         2: begin
            m_hold--;
            if (w || l || m_hold == 0) begin m_phase = 3; m_b = 0; end
         end
         default: if (!w && !l && yy != m_tgt) m_phase = 0;
      endcase
      if (yy == 4'd0) m_last = 0;
   endtask

   vec_t tbl[18];

   initial begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

      // Basic press/hold/release, then a win during the press.
      tbl[0]  = mk(1,0,0,4'h0,0,0, 4'h0,0,0,0,0);
      tbl[1]  = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[2]  = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[3]  = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[4]  = mk(0,1,0,4'h1,0,0, 4'h1,1,0,0,0);
      tbl[5]  = mk(0,1,0,4'h1,0,0, 4'h1,1,0,0,0);
      tbl[6]  = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[7]  = mk(0,1,0,4'h0,0,0, 4'h0,0,0,0,0);
      tbl[8]  = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[9]  = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[10] = mk(0,1,0,4'h1,0,0, 4'h0,1,0,0,0);
      tbl[11] = mk(0,1,0,4'h1,0,0, 4'h1,1,0,0,0);
      tbl[12] = mk(0,1,0,4'h1,1,0, 4'h0,1,1,0,0);
      tbl[13] = mk(0,1,0,4'h1,0,0, 4'h0,1,1,0,0);
      tbl[14] = mk(0,1,0,4'h1,0,0, 4'h0,1,1,0,0);
      tbl[15] = mk(0,1,0,4'h0,0,0, 4'h0,0,1,0,0);
      tbl[16] = mk(0,1,0,4'h1,0,0, 4'h0,1,1,0,0);
      tbl[17] = mk(0,1,0,4'h0,0,0, 4'h0,0,1,0,0);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].miss, tbl[i].y, tbl[i].win, tbl[i].lose);
         step();
         chk($sformatf("tbl%0d_b", i),      32'(b),      32'(tbl[i].eb));
         chk($sformatf("tbl%0d_busy", i),   32'(busy),   32'(tbl[i].ebusy));
         chk($sformatf("tbl%0d_wins", i),   32'(wins),   32'(tbl[i].ew));
         chk($sformatf("tbl%0d_losses", i), 32'(losses), 32'(tbl[i].el));
         chk($sformatf("tbl%0d_err", i),    32'(err),    32'(tbl[i].eerr));
      end

      // Deliberate miss on the top light wraps to the bottom one.
      do_reset();
      drive(1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("miss_wait%0d", i), 32'(b), 32'h0);
      end
      step();
      chk("miss_b", 32'(b), 32'h1);
      lose = 1'b1; miss = 1'b0;
      step();
      chk("miss_b_drop", 32'(b), 32'h0);
      chk("miss_losses", 32'(losses), 32'd1);
      chk("miss_wins", 32'(wins), 32'd0);

      // Target change while reacting restarts the delay.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
      step();
      y = 4'h4;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("retgt_wait%0d", i), 32'(b), 32'h0);
      end
      step();
      chk("retgt_b", 32'(b), 32'h4);

      // Aborts during the reaction delay: bad pattern, light off, disabled.
      for (int k = 0; k < 3; k++) begin
         do_reset();
         drive(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
         step();
         step();
         if (k == 0) y = 4'h6;
         else if (k == 1) y = 4'h0;
         else en = 1'b0;
         step();
         chk($sformatf("abort%0d_busy", k), 32'(busy), 32'h0);
         for (int i = 0; i < 4; i++) step();
         chk($sformatf("abort%0d_b", k), 32'(b), 32'h0);
         chk($sformatf("abort%0d_idle", k), 32'(busy), 32'h0);
      end

      // Reset in the middle of a press.
      do_reset();
      win = 1'b1; step();
      win = 1'b0; step();
      chk("rstp_wins_pre", 32'(wins), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("rstp_b_pre", 32'(b), 32'h1);
      reset = 1'b1;
      step();
      chk("rstp_b", 32'(b), 32'h0);
      chk("rstp_busy", 32'(busy), 32'h0);
      chk("rstp_wins", 32'(wins), 32'd0);
      reset = 1'b0;

      // Simultaneous win and lose.
      do_reset();
      win = 1'b1; step();
      win = 1'b0; step();
      win = 1'b1; lose = 1'b1; step();
      chk("both_err", 32'(err), 32'h1);
      win = 1'b0; lose = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("both_err_sticky", 32'(err), 32'h1);
      chk("both_wins", 32'(wins), 32'd1);
      chk("both_losses", 32'(losses), 32'd0);

      // Score saturation on the narrow instance.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         win = 1'b1; step();
         win = 1'b0; step();
      end
      chk("sat_wins2", 32'(wins2), 32'd3);
      chk("sat_wins8", 32'(wins), 32'd5);

      // Random stimulus against the model.
      begin
         logic [3:0] cy;
         logic r, e, m, w, l;
         logic [25:0] act, exp;
         cy = 4'h0;
         for (int c = 0; c < 4000; c++) begin
            if (c == 0) r = 1'b1;
            else r = ($urandom_range(199) == 0);
            if ($urandom_range(5) == 0) begin
               int sel;
               sel = int'($urandom_range(9));
               if (sel < 2) cy = 4'h0;
               else if (sel < 8) cy = 4'(1 << $urandom_range(3));
               else cy = 4'($urandom_range(15));
            end
            e = ($urandom_range(15) != 0);
            m = 1'($urandom_range(1));
            w = ($urandom_range(9) == 0);
            l = ($urandom_range(9) == 0);
            drive(r, e, m, cy, w, l);
            model_edge(r, e, m, cy, w, l);
            step();
            act = {b, busy, wins, losses, err, wins2, losses2};
            exp = {m_b, 1'(m_phase != 0), 8'(cap(m_wins, 255)), 8'(cap(m_losses, 255)),
                   1'(m_err), 2'(cap(m_wins, 3)), 2'(cap(m_losses, 3))};
            chk($sformatf("rand%0d", c), 32'(act), 32'(exp));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/guess_player.md
Name: guess_player

Overview:
- Automatic opponent for the guess-game FSM: watches the FSM's 4-bit light output `y` and drives the FSM's 4-bit button input `b`.
- Presses the lit button after a programmable reaction delay, or deliberately presses the wrong one, then holds and releases the press.
- Tallies the FSM's `win`/`lose` results in saturating score counters.
- Sits beside the game FSM in the board top as the responder end of the light/button interface; also used as a self-checking stimulus source in benches.

Parameters:
- DELAY, 3, reaction cycles from a new light to the press; legal range 1..255.
- HOLD, 2, cycles `b` stays asserted if no result arrives; legal range 1..255.
- SCORE_W, 8, width of each score counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  1 = player active; 0 = never starts a new press.
- miss  input  1  0 = press the lit button; 1 = press the lit button rotated left by one (deliberate loss).
- y  input  4  light pattern from the game FSM; one-hot = target, 0 = no target.
- win  input  1  game FSM win indication (level).
- lose  input  1  game FSM lose indication (level).
- b  output  4  button drive to the game FSM; registered.
- wins  output  SCORE_W  count of `win` rising edges.
- losses  output  SCORE_W  count of `lose` rising edges.
- busy  output  1  high in ARMED, PRESS and RELEASE.
- err  output  1  sticky; set when `win` and `lose` are high in the same cycle.

Behaviour:
- Reset (synchronous, active-high), effective at the next rising edge:
  - state=IDLE, `b`=0, `wins`=0, `losses`=0, `busy`=0, `err`=0.
  - All internal counters and the target register clear.
  - Reset mid-press drops `b` to 0 at that same edge.
- All outputs are registered; no combinational path from input to output.
- "Valid target" means `y` is one-hot; `$onehot` semantics are required.
- States: IDLE, ARMED, PRESS, RELEASE.
- IDLE:
  - `b`=0.
  - If `en`=1, `y` is valid, and `y`!=`last`: capture `tgt`=`y`, clear `dcnt`, go to ARMED.
  - `last` holds the most recently pressed target; it clears to 0 on reset and whenever `y`=0 is sampled.
- ARMED (counting the reaction delay):
  - If `y` changes to a different valid value: recapture `tgt`, clear `dcnt`, stay in ARMED.
  - If `y`=0, `y` is not one-hot, or `en`=0: go to IDLE, no press.
  - If `win` or `lose` rises: go to IDLE, no press.
  - Otherwise increment `dcnt`. At the edge where `dcnt`==DELAY-1, go to PRESS and load `b` in the same edge:
    - `b`=`tgt` if `miss`=0.
    - `b`={`tgt`[2:0],`tgt`[3]} if `miss`=1.
  - Latency: for a valid `y` first sampled at edge E0, `b` is nonzero after edge E0+DELAY.
- PRESS:
  - `b` is held constant; `miss` and `y` changes are ignored.
  - `last`=`tgt` is recorded on entry.
  - `hcnt` counts up. Leave when `win`=1, `lose`=1, or `hcnt`==HOLD-1.
  - On leaving, go to RELEASE with `b`=0 at that edge.
- RELEASE:
  - `b`=0.
  - Go to IDLE when `win`=0, `lose`=0, and `y`!=`tgt`, all in the same cycle.
  - This prevents re-pressing a light that is still shown.
- `busy`=1 in ARMED, PRESS and RELEASE (registered alongside the state).
- Score logic runs in every state, independent of `en`:
  - Detect rising edges of `win` and `lose` using registered previous values, which clear on reset.
  - On a `win` rise, `wins`+1, saturating at 2^SCORE_W-1.
  - On a `lose` rise, `losses`+1, saturating at 2^SCORE_W-1.
  - If `win` and `lose` are both high in the same cycle: set `err`, increment neither counter that cycle, and treat as a result in PRESS (go to RELEASE).
  - `err` clears only on reset.
- Illegal state encoding: go to IDLE with `b`=0.

Decomposition:
- Package `guess_pkg`:
  - `player_state_t` enum {IDLE, ARMED, PRESS, RELEASE}.
  - `localparam int NLIGHTS = 4`.
  - A `rotl1` function for the miss pattern.
- Sub-module `sat_counter` (parameter W; ports `clk`, `reset`, `inc`, `q`):
  - Synchronous-reset saturating incrementer.
  - Instantiated twice, for `wins` and `losses`.
- The FSM, delay/hold counters and edge detect stay in `guess_player`.

Test Plan:
- Reset, `en`=1, `miss`=0, DELAY=3, HOLD=2, `y`=0001 first sampled at E0:
  - `b`=0001 after E3 and stays 0001 for 2 cycles, then `b`=0.
  - `busy`=1 from E1.
- Same setup, then FSM raises `win` 1 cycle into PRESS:
  - `b`=0 at the next edge and `wins`=1, `losses`=0.
  - No re-press while `y`=0001 persists; re-arms after `y`=0000 then `y`=0001.
- `miss`=1, `y`=1000:
  - `b`=0001 after DELAY.
  - Driving `lose` high gives `losses`=1.
- Target change: `y`=0010 at E0, then `y`=0100 at E1:
  - `b`=0100 after E1+3; 0010 is never driven.
- Aborts:
  - `y`=0110 (not one-hot), `y`=0, or `en`=0 during ARMED: `b` stays 0 and the state returns to IDLE.
  - `reset`=1 during PRESS: `b`=0 and counters=0 after that edge.
- Simultaneous `win`=`lose`=1 for 1 cycle:
  - `err`=1 sticky; `wins` and `losses` unchanged.
- Saturation, with SCORE_W=2 and 5 `win` pulses: `wins` holds 3.
